// File: rtl/aes_pin_master_if.sv
// rtl/aes_pin_master_if.sv - 8-bit pin-level AES bus between host initiator and chip top
// One transaction per valid cycle; rdata returns a fixed number of cycles after a read.
interface aes_pin_master_if;
  logic       valid;
  logic       wen;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output valid,
    output wen,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wen,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/aes_pin_master.sv
// rtl/aes_pin_master.sv - host-side initiator running a full AES encrypt over the pin bus
// Writes key, plaintext and start command, polls status, then reads back the ciphertext.
module aes_pin_master #(
  parameter logic [7:0] KEY_BASE  = 8'h00,
  parameter logic [7:0] PT_BASE   = 8'h10,
  parameter logic [7:0] CT_BASE   = 8'h20,
  parameter logic [7:0] CTRL_ADDR = 8'h40,
  parameter logic [7:0] STAT_ADDR = 8'h41,
  parameter int         RD_LAT    = 1,
  parameter int         POLL_MAX  = 1023
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [127:0]        key,
  input  logic [127:0]        pt,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [127:0]        ct,
  aes_pin_master_if.master    bus
);

  localparam int              PW        = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_MAX);
  localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, WKEY, WPT, GO, POLL, PWAIT, RDCT, RWAIT, FIN, ERR
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [1:0]     wait_q, wait_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           tout_q, tout_d;
  logic           valid_q, valid_d;
  logic           wen_q, wen_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    wait_d  = wait_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          pt_d    = pt;
          ct_d    = '0;
          idx_d   = 4'd0;
          poll_d  = '0;
          state_d = WKEY;
        end
      end
      WKEY: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = WPT;
      end
      WPT: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = GO;
      end
      GO: state_d = POLL;
      POLL: begin
        poll_d  = poll_q + 1'b1;
        wait_d  = 2'd0;
        state_d = PWAIT;
      end
      PWAIT: begin
        if (wait_q == WAIT_LAST) begin
          if (bus.rdata[0]) begin
            idx_d   = 4'd0;
            state_d = RDCT;
          end else if (poll_q == POLL_LAST) begin
            state_d = ERR;
          end else begin
            state_d = POLL;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      RDCT: begin
        wait_d  = 2'd0;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (wait_q == WAIT_LAST) begin
          ct_d[{idx_q, 3'b000} +: 8] = bus.rdata;
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == 4'd15) ? FIN : RDCT;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus pins are registered from the next state so each transaction lines up with its state.
    valid_d = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_d)
      WKEY: begin
        valid_d = 1'b1;
        wen_d   = 1'b1;
        addr_d  = KEY_BASE + {4'h0, idx_d};
        wdata_d = key_d[{idx_d, 3'b000} +: 8];
      end
      WPT: begin
        valid_d = 1'b1;
        wen_d   = 1'b1;
        addr_d  = PT_BASE + {4'h0, idx_d};
        wdata_d = pt_d[{idx_d, 3'b000} +: 8];
      end
      GO: begin
        valid_d = 1'b1;
        wen_d   = 1'b1;
        addr_d  = CTRL_ADDR;
        wdata_d = 8'h01;
      end
      POLL: begin
        valid_d = 1'b1;
        addr_d  = STAT_ADDR;
      end
      RDCT: begin
        valid_d = 1'b1;
        addr_d  = CT_BASE + {4'h0, idx_d};
      end
      default: ;
    endcase

    busy_d = state_d inside {WKEY, WPT, GO, POLL, PWAIT, RDCT, RWAIT};
    done_d = (state_d == FIN);
    tout_d = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      poll_q  <= '0;
      wait_q  <= 2'd0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      valid_q <= valid_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tout_q;
  assign ct          = ct_q;
  assign bus.valid   = valid_q;
  assign bus.wen     = wen_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;

endmodule

// File: doc/aes_pin_master.md
Name: aes_pin_master

Overview:
- Host-side initiator for the 8-bit pin-level AES bus (valid/wen/addr/wdata/rdata) exposed by the AES chip top.
- Accepts a 128-bit key and a 128-bit plaintext, then performs the whole AES operation over that bus:
  - writes the key and plaintext one byte per transaction;
  - writes the start command and polls the status byte;
  - reads back 16 ciphertext bytes.
- Used in the board-level testbench and as an FPGA-side driver for silicon bring-up.
- The scan pins are not driven by this block.

Parameters:
- KEY_BASE, 8'h00, address of key byte 0; key byte i is written to KEY_BASE+i.
- PT_BASE, 8'h10, address of plaintext byte 0.
- CT_BASE, 8'h20, address of ciphertext byte 0.
- CTRL_ADDR, 8'h40, control address; writing 8'h01 starts encryption.
- STAT_ADDR, 8'h41, status address; bit 0 = done.
- RD_LAT, 1, cycles from the read-request cycle to the cycle in which rdata is sampled (1..4).
- POLL_MAX, 1023, maximum status reads before the block aborts with a timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- key  input  128  key; byte i = key[8i+7:8i]; captured on accept.
- pt  input  128  plaintext; same byte order; captured on accept.
- busy  output  1  high from the cycle after accept until done or timeout_err pulses.
- done  output  1  one-cycle pulse; ct is valid from this cycle on.
- timeout_err  output  1  one-cycle pulse on poll timeout.
- ct  output  128  ciphertext; byte i = ct[8i+7:8i]; holds its value until the next accept.
- valid  output  1  bus transaction strobe.
- wen  output  1  1 = write, 0 = read; meaningful only while valid=1.
- addr  output  8  bus address.
- wdata  output  8  write byte.
- rdata  input  8  read byte.

Behaviour:
- Reset values: all outputs 0 (busy, done, timeout_err, ct, valid, wen, addr, wdata); FSM in IDLE; internal key/pt registers 0.
- Bus rules:
  - Write = one cycle of valid=1, wen=1 with addr/wdata.
  - Read = one cycle of valid=1, wen=0; rdata is sampled exactly RD_LAT cycles later.
  - valid is 0 during read-wait cycles.
  - addr and wdata hold their last values when valid=0.
  - Only one transaction is outstanding at a time.
- FSM states and transitions:
  - IDLE: on start=1, capture key and pt, clear the byte counter (idx) and poll counter, go to WKEY.
  - WKEY: write key byte idx to KEY_BASE+idx, one byte per cycle; after idx=15, reset idx and go to WPT.
  - WPT: same pattern for plaintext at PT_BASE+idx, 16 cycles; then go to GO.
  - GO: write 8'h01 to CTRL_ADDR (1 cycle); go to POLL.
  - POLL: issue a read of STAT_ADDR, increment the poll counter, go to PWAIT.
  - PWAIT: wait RD_LAT cycles, then sample rdata.
    - bit 0 = 1: go to RDCT with idx=0.
    - bit 0 = 0 and poll counter = POLL_MAX: go to ERR.
    - otherwise: go back to POLL.
  - RDCT/RWAIT: for each idx 0..15, read CT_BASE+idx, wait RD_LAT cycles, store rdata in ct byte idx; after byte 15 go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
  - ERR: timeout_err=1 for one cycle, busy=0, return to IDLE; ct is left as partially/previously held.
- Latency: the first key write occurs in the cycle after accept.
  - Write phase: 33 bus cycles.
  - Each status poll: 1+RD_LAT cycles.
  - Ciphertext read phase: 16*(1+RD_LAT) cycles.
- Address arithmetic is 8-bit and wraps modulo 256.
- start while busy is ignored with no side effects. start in the same cycle as FIN/ERR is also ignored; start is sampled only in IDLE.
- ct is cleared to 0 on accept, so partial results are never mixed with old data.
- resetn asserted mid-operation: everything returns to reset values immediately, and valid drops asynchronously. The bus must see no further transactions after resetn is deasserted until a new start.

Test Plan:
- Reset idle: hold resetn=0 for 3 cycles, release, 10 idle cycles -> valid, busy, done and timeout_err stay 0; ct=0.
- Write sequence: start with key=128'h0f0e..00 and pt=128'h1f1e..10 -> 16 writes at addr 00..0f with wdata 00..0f, then 16 writes at 10..1f with wdata 10..1f, then a write at 40 with data 01. All are back-to-back and start one cycle after start.
- Full encrypt, RD_LAT=1: the bus model sets the status done bit on the 3rd poll and returns ct byte i = 8'hA0+i -> exactly 3 reads of 41; ct=128'hAFAE..A0; done pulses once. Total from accept = 33+3*2+16*2+1 cycles.
- Timeout, POLL_MAX=4: status is never set -> 4 reads of 41, then timeout_err pulses, busy falls, no reads of 20..2f.
- Start while busy: pulse start again during WPT with different key/pt -> the sequence is unchanged and no second done follows.
- Mid-operation reset: assert resetn during POLL with RD_LAT=3 -> valid=0 immediately and busy=0. A new start then completes normally with the correct ct.
